// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants, types and helpers for the pipelined CLA add/sub
package addsub_pkg;

  localparam int GROUP_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Control that travels with an operation between stages (valid is kept apart
  // because it is the only field that must be cleared by reset).
  typedef struct packed {
    op_e  op;
    logic carry;
  } stage_ctl_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Bits resolved per pipeline stage, rounded down to whole lookahead groups.
  function automatic int slice_width(input int width, input int stages);
    return ((width / stages) / GROUP_W) * GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group_gp.sv
// rtl/cla_group_gp.sv - 4-bit carry-lookahead group with sum and group generate/propagate
module cla_group_gp
  import addsub_pkg::*;
(
  input  logic [GROUP_W-1:0] a_i,
  input  logic [GROUP_W-1:0] b_i,
  input  logic               cin_i,
  output logic [GROUP_W-1:0] sum_o,
  output logic               g_o,
  output logic               p_o
);

  logic [GROUP_W-1:0] gen;
  logic [GROUP_W-1:0] prop;
  logic [GROUP_W-1:0] c;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Carry into each bit expanded directly from the group carry-in
  always_comb begin
    c    = '0;
    c[0] = cin_i;
    c[1] = gen[0] | (prop[0] & cin_i);
    c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin_i);
    c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
         | (prop[2] & prop[1] & prop[0] & cin_i);
  end

  assign sum_o = prop ^ c;
  assign g_o   = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p_o   = &prop;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor with flags and handshake
module pipelined_cla_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int NG = SW / GROUP_W;

  logic             en;
  op_e              op_in;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             fin_valid;
  op_e              fin_op;
  logic [TAG_W-1:0] fin_tag;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_carry;
  logic             fin_cmsb;
  flags_t           fin_flags;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  flags_t           out_flags_q;
  logic [TAG_W-1:0] out_tag_q;

  // Whole pipeline moves together; a stalled output freezes every stage.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Subtraction is A + ~B + ~borrow_in, so the borrow is the inverted raw carry.
  assign op_in = op_e'(in_sub);
  assign b_eff = (op_in == OP_SUB) ? ~in_b : in_b;
  assign c0    = (op_in == OP_SUB) ? ~in_cin : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM_IN = WIDTH - k * SW;
    localparam int DONE   = (k + 1) * SW;

    logic              valid_s;
    stage_ctl_t        ctl_s;
    logic [TAG_W-1:0]  tag_s;
    logic [REM_IN-1:0] a_rem_s;
    logic [REM_IN-1:0] b_rem_s;
    logic [DONE-1:0]   acc_s;
    logic [SW-1:0]     sum_s;
    logic [NG-1:0]     grp_g;
    logic [NG-1:0]     grp_p;
    logic [NG:0]       gc;
    logic              run;

    if (k == 0) begin : g_src
      assign valid_s = in_valid;
      assign ctl_s   = '{op: op_in, carry: c0};
      assign tag_s   = in_tag;
      assign a_rem_s = in_a;
      assign b_rem_s = b_eff;
      assign acc_s   = sum_s;
    end else begin : g_src
      assign valid_s = g_stage[k-1].g_reg.valid_q;
      assign ctl_s   = g_stage[k-1].g_reg.ctl_q;
      assign tag_s   = g_stage[k-1].g_reg.tag_q;
      assign a_rem_s = g_stage[k-1].g_reg.a_rem_q;
      assign b_rem_s = g_stage[k-1].g_reg.b_rem_q;
      assign acc_s   = {sum_s, g_stage[k-1].g_reg.acc_q};
    end

    for (genvar j = 0; j < NG; j++) begin : g_group
      cla_group_gp u_grp (
        .a_i   (a_rem_s[j*GROUP_W +: GROUP_W]),
        .b_i   (b_rem_s[j*GROUP_W +: GROUP_W]),
        .cin_i (gc[j]),
        .sum_o (sum_s[j*GROUP_W +: GROUP_W]),
        .g_o   (grp_g[j]),
        .p_o   (grp_p[j])
      );
    end

    // Each group carry is formed from the slice carry-in and group (g, p) terms only
    always_comb begin
      gc  = '0;
      run = 1'b0;
      for (int j = 0; j <= NG; j++) begin
        run = ctl_s.carry;
        for (int i = 0; i < j; i++) begin
          run = grp_g[i] | (grp_p[i] & run);
        end
        gc[j] = run;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      localparam int REM_OUT = REM_IN - SW;

      logic               valid_q;
      stage_ctl_t         ctl_q;
      logic [TAG_W-1:0]   tag_q;
      logic [REM_OUT-1:0] a_rem_q;
      logic [REM_OUT-1:0] b_rem_q;
      logic [DONE-1:0]    acc_q;

      // Stage occupancy; cleared by reset so in-flight ops are dropped
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
        end else if (en) begin
          valid_q <= valid_s;
        end
      end

      // Slice carry, finished low sum bits and untouched high operand bits move up
      always_ff @(posedge clk) begin
        if (en) begin
          ctl_q   <= '{op: ctl_s.op, carry: gc[NG]};
          tag_q   <= tag_s;
          a_rem_q <= a_rem_s[REM_IN-1:SW];
          b_rem_q <= b_rem_s[REM_IN-1:SW];
          acc_q   <= acc_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      assign fin_valid = valid_s;
      assign fin_op    = ctl_s.op;
      assign fin_tag   = tag_s;
      assign fin_sum   = acc_s;
      assign fin_carry = gc[NG];
      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
      assign fin_cmsb  = a_rem_s[SW-1] ^ b_rem_s[SW-1] ^ sum_s[SW-1];
    end
  end

  assign fin_flags = '{
    cout: fin_carry ^ (fin_op == OP_SUB),
    ovf:  fin_cmsb ^ fin_carry,
    zero: (fin_sum == '0)
  };

  // Result register; holds the last result whenever no new one arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_flags_q <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        out_sum_q   <= fin_sum;
        out_flags_q <= fin_flags;
        out_tag_q   <= fin_tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_flags_q.cout;
  assign out_ovf   = out_flags_q.ovf;
  assign out_zero  = out_flags_q.zero;
  assign out_tag   = out_tag_q;

endmodule
